// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   WORD_WIDTH   : instruction/data word width (fixed at 32)
//   BOOT_LEN_W   : width of the image length field and word index
//   BOOT_ST_W    : width of the loader state encoding
//   boot_state_e : loader FSM states
//   word_addr()  : byte address of word idx relative to a base
package imem_boot_loader_pkg;

  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned BOOT_LEN_W = 16;
  localparam int unsigned BOOT_ST_W  = 3;

  typedef enum logic [BOOT_ST_W-1:0] {
    ST_LEN0 = 3'd0,
    ST_LEN1 = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } boot_state_e;

  // Address arithmetic wraps mod 2^WORD_WIDTH; no overflow check by design.
  function automatic logic [WORD_WIDTH-1:0] word_addr(
    input logic [WORD_WIDTH-1:0] base,
    input logic [BOOT_LEN_W-1:0] idx
  );
    return base + WORD_WIDTH'({idx, 2'b00});
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
//   in_valid/in_ready/in_byte : byte stream handshake (accept on valid && ready)
//   imem_we/imem_addr/imem_data : one-cycle write strobe into instruction memory
// Modports: slave = the loader, master = stream source plus memory write sink.
interface imem_boot_loader_if #(
  parameter int unsigned W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_byte;
  logic         imem_we;
  logic [W-1:0] imem_addr;
  logic [W-1:0] imem_data;

  modport master (
    output in_valid, in_byte,
    input  in_ready, imem_we, imem_addr, imem_data
  );

  modport slave (
    input  in_valid, in_byte,
    output in_ready, imem_we, imem_addr, imem_data
  );
endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs accepted stream bytes into little-endian 32-bit words.
//   clk, rst     : clock and synchronous active-high reset
//   i_en         : a data byte is accepted this cycle
//   i_byte       : the accepted byte
//   o_word       : assembled word including the current byte (valid with o_word_valid)
//   o_word_valid : combinational pulse on the cycle that accepts byte 3 of a word
module imem_boot_loader_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [1:0]  r_cnt;
  logic [23:0] r_shift;

  // Bytes shift in from the top, so after three bytes r_shift = {b2, b1, b0}.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_en) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {i_byte, r_shift[23:8]};
    end
  end

  assign o_word       = {i_byte, r_shift};
  assign o_word_valid = i_en && (r_cnt == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed program image as a
// byte stream, writes it word by word into instruction memory and releases the
// CPU reset once the checksum matches.
//   clk, rst : clock and synchronous active-high reset
//   bus      : stream input and imem write port (slave modport)
//   cpu_rst  : CPU reset, high until the image is verified
//   done     : image loaded and verified (sticky until rst)
//   error    : bad length or checksum mismatch (sticky until rst)
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned           W         = WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0] ADDR_BASE = '0,
  parameter int unsigned           MAX_WORDS = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_boot_loader_if.slave    bus,
  output logic                 cpu_rst,
  output logic                 done,
  output logic                 error
);

  localparam logic [31:0] LP_MAX_WORDS = 32'(MAX_WORDS);

  boot_state_e           r_state;
  logic                  r_ready;
  logic                  r_we;
  logic [W-1:0]          r_addr;
  logic [W-1:0]          r_data;
  logic                  r_cpu_rst;
  logic                  r_done;
  logic                  r_error;
  logic [7:0]            r_len_lo;
  logic [BOOT_LEN_W-1:0] r_nwords;
  logic [BOOT_LEN_W-1:0] r_widx;
  logic [7:0]            r_csum;

  logic                  w_accept;
  logic                  w_data_en;
  logic [BOOT_LEN_W-1:0] w_len;
  logic [31:0]           w_word;
  logic                  w_word_valid;

  assign w_accept  = bus.in_valid && r_ready;
  assign w_data_en = w_accept && (r_state == ST_DATA);
  assign w_len     = {bus.in_byte, r_len_lo};

  imem_boot_loader_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_en         (w_data_en),
    .i_byte       (bus.in_byte),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_LEN0;
      r_ready   <= 1'b1;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_len_lo  <= '0;
      r_nwords  <= '0;
      r_widx    <= '0;
      r_csum    <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_accept) begin
        r_csum <= r_csum ^ bus.in_byte;
        unique case (r_state)
          ST_LEN0: begin
            r_len_lo <= bus.in_byte;
            r_state  <= ST_LEN1;
          end
          ST_LEN1: begin
            r_nwords <= w_len;
            if (w_len == '0) begin
              r_state <= ST_CSUM;
            end else if (32'(w_len) > LP_MAX_WORDS) begin
              r_state <= ST_ERR;
              r_ready <= 1'b0;
              r_error <= 1'b1;
            end else begin
              r_state <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (w_word_valid) begin
              r_we   <= 1'b1;
              r_addr <= word_addr(ADDR_BASE, r_widx);
              r_data <= w_word;
              r_widx <= r_widx + 1'b1;
              if (r_widx == r_nwords - 1'b1) begin
                r_state <= ST_CSUM;
              end
            end
          end
          ST_CSUM: begin
            // r_csum already covers every byte before this one.
            r_ready <= 1'b0;
            if (bus.in_byte == r_csum) begin
              r_state   <= ST_RUN;
              r_cpu_rst <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_state <= ST_ERR;
              r_error <= 1'b1;
            end
          end
          ST_RUN, ST_ERR: begin
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = r_ready;
  assign bus.imem_we   = r_we;
  assign bus.imem_addr = r_addr;
  assign bus.imem_data = r_data;
  assign cpu_rst       = r_cpu_rst;
  assign done          = r_done;
  assign error         = r_error;

endmodule
